// File: rtl/snn_interfaces_pkg.sv
// Shared SNN datapath types and scheduler defaults.
// An output_vector_t is one spike event as handed to the convolution engine.
package snn_interfaces_pkg;

    localparam int TS_W  = 8;
    localparam int XY_W  = 6;
    localparam int SPK_W = 2;

    typedef struct packed {
        logic [TS_W-1:0]  timestep;
        logic [XY_W-1:0]  x;
        logic [XY_W-1:0]  y;
        logic [SPK_W-1:0] spikes;
    } output_vector_t;

    localparam int SCHED_DEFAULT_DEPTH   = 8;
    localparam int SCHED_DEFAULT_TIMEOUT = 255;

    function automatic logic has_spikes(input output_vector_t ev);
        return |ev.spikes;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO of output_vector_t; dout is the head entry while !empty.
// Push and pop in the same cycle are both honoured, even when full.
module event_fifo
    import snn_interfaces_pkg::*;
#(
    parameter int DEPTH = SCHED_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  output_vector_t           din,
    input  logic                     pop,
    output output_vector_t           dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    output_vector_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_event_scheduler.sv
// Round-robin merge of N_SRC event requesters into a queue feeding Convolution2d,
// issuing one event at a time with a valid/ack handshake and an ack watchdog.
module conv_event_scheduler
    import snn_interfaces_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int FIFO_DEPTH  = SCHED_DEFAULT_DEPTH,
    parameter int ACK_TIMEOUT = SCHED_DEFAULT_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_SRC-1:0]                  src_valid,
    input  output_vector_t [N_SRC-1:0]        src_event,
    output logic [N_SRC-1:0]                  src_ready,
    output output_vector_t                    conv_event,
    output logic                              conv_valid,
    input  logic                              conv_ack,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              busy,
    output logic                              err_timeout,
    input  logic                              clear_err
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_SRC  = PW'(N_SRC - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt_idx;
    logic [N_SRC-1:0] gnt;
    logic            gnt_any;
    logic            accept;
    output_vector_t  sel_event;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    output_vector_t  fifo_dout;
    logic [TW-1:0]   tcnt;
    logic            timeout_fire;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!gnt_any && src_valid[(int'(rr_ptr) + k) % N_SRC]) begin
                gnt[(int'(rr_ptr) + k) % N_SRC] = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % N_SRC);
                gnt_any = 1'b1;
            end
        end
    end

    assign src_ready = fifo_full ? '0 : gnt;
    assign accept    = gnt_any && !fifo_full;
    assign sel_event = src_event[gnt_idx];
    // Zero-spike events complete the handshake but never occupy the queue.
    assign fifo_push = accept && has_spikes(sel_event);
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gnt_idx == LAST_SRC) ? '0 : gnt_idx + PW'(1);
        end
    end

    event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (sel_event),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign timeout_fire = (state == ISSUE) && !conv_ack && (tcnt == TCNT_LAST);
    assign busy         = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            conv_valid  <= 1'b0;
            conv_event  <= '0;
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        conv_event <= fifo_dout;
                        conv_valid <= 1'b1;
                        tcnt       <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (conv_ack || timeout_fire) begin
                        conv_valid <= 1'b0;
                        tcnt       <= '0;
                        state      <= GAP;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase

            // A clear in the same cycle as a timeout wins.
            if (clear_err) begin
                err_timeout <= 1'b0;
            end else if (timeout_fire) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_event_scheduler.sv
// Self-checking bench for conv_event_scheduler: scoreboard of accepted events
// compared at each fresh rise of conv_valid, plus per-scenario inline checks.
module tb_conv_event_scheduler;
    import snn_interfaces_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int TMO   = 255;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N-1:0]          src_valid = '0;
    output_vector_t [N-1:0] src_event = '0;
    logic [N-1:0]          src_ready;
    output_vector_t        conv_event;
    logic                  conv_valid;
    logic                  conv_ack = 1'b0;
    logic [3:0]            fifo_count;
    logic                  busy;
    logic                  err_timeout;
    logic                  clear_err = 1'b0;

    always #5 clk = ~clk;

    conv_event_scheduler #(.N_SRC(N), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_event   (src_event),
        .src_ready   (src_ready),
        .conv_event  (conv_event),
        .conv_valid  (conv_valid),
        .conv_ack    (conv_ack),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .err_timeout (err_timeout),
        .clear_err   (clear_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int issued   = 0;
    output_vector_t exp_q[$];
    output_vector_t exp_ev;
    output_vector_t held;
    logic prev_valid = 1'b0;

    function automatic output_vector_t mk(input int ts, input int xx, input int yy, input int sp);
        output_vector_t r;
        r.timestep = 8'(ts);
        r.x        = 6'(xx);
        r.y        = 6'(yy);
        r.spikes   = 2'(sp);
        return r;
    endfunction

    // Expected queue contents: every nonzero-spike event at a completed handshake.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && src_ready[i] && src_event[i].spikes != 2'd0) begin
                    exp_q.push_back(src_event[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (conv_valid && !prev_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: issued %h, scoreboard empty", conv_event);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (conv_event !== exp_ev) begin
                        n_fail++;
                        $display("FAIL sb_event: got %h expected %h", conv_event, exp_ev);
                    end
                end
                held = conv_event;
                issued++;
            end else if (conv_valid) begin
                n_checks++;
                if (conv_event !== held) begin
                    n_fail++;
                    $display("FAIL sb_stable: got %h expected %h", conv_event, held);
                end
            end
            prev_valid = conv_valid;
        end
    end

    task automatic do_reset;
        @(negedge clk);
        src_valid = '0;
        conv_ack  = 1'b0;
        clear_err = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        ok = busy == 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            ok = busy == 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if (conv_valid !== 1'b0 || conv_event !== '0) begin
            n_fail++; $display("FAIL rst_conv: valid=%b event=%h, need 0/0", conv_valid, conv_event);
        end
        n_checks++;
        if (fifo_count !== 4'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_fifo: count=%0d busy=%b, need 0/0", fifo_count, busy);
        end
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL rst_err: got %b need 0", err_timeout);
        end
        n_checks++;
        if (src_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rst_ready_idle: got %b need 0000", src_ready);
        end
        rst = 1'b0;
        src_valid = 4'hF;
        #1;
        n_checks++;
        if (src_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rst_rr: got %b need 0001", src_ready);
        end
        src_valid = '0;
    endtask

    task automatic test_single;
        output_vector_t ev;
        do_reset;
        ev = mk(0, 5, 3, 3);
        src_event[0] = ev;
        src_valid = 4'b0001;
        #1;
        n_checks++;
        if (src_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b need 0001", src_ready);
        end
        @(posedge clk);
        #1 src_valid = '0;
        @(negedge clk);
        n_checks++;
        if (conv_valid !== 1'b0 || fifo_count !== 4'd1) begin
            n_fail++; $display("FAIL single_t1: valid=%b count=%0d, need 0/1", conv_valid, fifo_count);
        end
        @(negedge clk);
        n_checks++;
        if (conv_valid !== 1'b1 || conv_event !== ev || fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL single_lat: valid=%b event=%h count=%0d, need 1/%h/0", conv_valid, conv_event, fifo_count, ev);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (conv_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_hold: valid=%b need 1", conv_valid);
        end
        conv_ack = 1'b1;
        @(negedge clk);
        conv_ack = 1'b0;
        n_checks++;
        if (conv_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_gap: valid=%b busy=%b, need 0/1", conv_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (conv_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL single_done: valid=%b busy=%b pending=%0d, need 0/0/0", conv_valid, busy, exp_q.size());
        end
    endtask

    task automatic test_zero_spike;
        logic bad;
        do_reset;
        src_event[1] = mk(1, 1, 1, 0);
        src_valid = 4'b0010;
        #1;
        n_checks++;
        if (src_ready !== 4'b0010) begin
            n_fail++; $display("FAIL zero_ready: got %b need 0010", src_ready);
        end
        @(posedge clk);
        #1 src_valid = '0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (conv_valid !== 1'b0 || fifo_count !== 4'd0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL zero_drop: valid=%b count=%0d busy=%b, need 0/0/0", conv_valid, fifo_count, busy);
        end
        src_valid = 4'hF;
        #1;
        n_checks++;
        if (src_ready !== 4'b0100) begin
            n_fail++; $display("FAIL zero_rr: got %b need 0100", src_ready);
        end
        src_valid = '0;
    endtask

    task automatic test_round_robin;
        int exp_ptr;
        int cnt [N];
        int total;
        logic [3:0] oh;
        logic ok;
        do_reset;
        conv_ack = 1'b1;
        exp_ptr = 0;
        total = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) src_event[i] = mk(i * 64 + cyc, i, cyc, 1);
            src_valid = 4'hF;
            #1;
            if (src_ready !== 4'b0000) begin
                oh = 4'b0001 << exp_ptr;
                n_checks++;
                if (src_ready !== oh) begin
                    n_fail++; $display("FAIL rr_grant: got %b need %b", src_ready, oh);
                end
                cnt[exp_ptr]++;
                total++;
                exp_ptr = (exp_ptr + 1) % N;
            end
        end
        @(negedge clk);
        src_valid = '0;
        n_checks++;
        if (total < 12 || cnt[0] < 3 || cnt[1] < 3 || cnt[2] < 3 || cnt[3] < 3) begin
            n_fail++; $display("FAIL rr_starve: counts %0d %0d %0d %0d, need each >= 3", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        wait_idle(ok);
        conv_ack = 1'b0;
        n_checks++;
        if (!ok || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rr_drain: idle=%b pending=%0d, need 1/0", ok, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int sent;
        int base;
        logic ok;
        do_reset;
        sent = 0;
        base = issued;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            src_valid[0] = (sent < 12);
            src_event[0] = mk(100 + sent, 2, 2, 1);
            #1;
            if (src_valid[0] && src_ready[0]) sent++;
        end
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 4'd8 || src_ready !== 4'b0000) begin
            n_fail++; $display("FAIL bp_full: count=%0d ready=%b, need 8/0000", fifo_count, src_ready);
        end
        n_checks++;
        if (sent != 9 || conv_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_accepted: sent=%0d valid=%b, need 9/1", sent, conv_valid);
        end
        src_valid = '0;
        conv_ack = 1'b1;
        wait_idle(ok);
        conv_ack = 1'b0;
        n_checks++;
        if (!ok || issued - base != 9 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_release: idle=%b issued=%0d pending=%0d, need 1/9/0", ok, issued - base, exp_q.size());
        end
    endtask

    task automatic test_timeout;
        logic got;
        logic ok;
        do_reset;
        @(negedge clk);
        src_event[3] = mk(200, 7, 7, 1);
        src_valid = 4'b1000;
        @(negedge clk);
        src_event[3] = mk(201, 8, 8, 2);
        @(negedge clk);
        src_valid = '0;
        got = conv_valid;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = conv_valid;
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL tmo_issue: conv_valid never rose");
        end
        repeat (TMO - 1) @(negedge clk);
        n_checks++;
        if (conv_valid !== 1'b1 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL tmo_before: valid=%b err=%b, need 1/0", conv_valid, err_timeout);
        end
        @(negedge clk);
        n_checks++;
        if (conv_valid !== 1'b0 || err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL tmo_fire: valid=%b err=%b, need 0/1", conv_valid, err_timeout);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (conv_valid !== 1'b1 || conv_event.timestep !== 8'd201 || err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL tmo_next: valid=%b ts=%0d err=%b, need 1/201/1", conv_valid, conv_event.timestep, err_timeout);
        end
        conv_ack = 1'b1;
        @(negedge clk);
        conv_ack = 1'b0;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clear: err=%b need 0", err_timeout);
        end
        // Second timeout with clear_err asserted on the very cycle it fires.
        src_event[3] = mk(202, 9, 9, 3);
        src_valid = 4'b1000;
        @(negedge clk);
        src_valid = '0;
        got = conv_valid;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = conv_valid;
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL tmo_issue2: conv_valid never rose");
        end
        repeat (TMO - 1) @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        n_checks++;
        if (err_timeout !== 1'b0 || conv_valid !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clr_prio: err=%b valid=%b, need 0/0", err_timeout, conv_valid);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL tmo_drain: idle=%b err=%b, need 1/0", ok, err_timeout);
        end
    endtask

    task automatic test_reset_mid_issue;
        logic bad;
        do_reset;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            src_event[2] = mk(50 + k, k, k, 1);
            src_valid = 4'b0100;
        end
        @(negedge clk);
        src_valid = '0;
        n_checks++;
        if (fifo_count !== 4'd3 || conv_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: count=%0d valid=%b, need 3/1", fifo_count, conv_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (conv_valid !== 1'b0 || fifo_count !== 4'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: valid=%b count=%0d busy=%b, need 0/0/0", conv_valid, fifo_count, busy);
        end
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 src_valid = 4'hF;
        #1;
        n_checks++;
        if (src_ready !== 4'b0001) begin
            n_fail++; $display("FAIL mid_rr: got %b need 0001", src_ready);
        end
        src_valid = '0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (conv_valid !== 1'b0 || fifo_count !== 4'd0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL mid_lost: valid=%b count=%0d, need 0/0", conv_valid, fifo_count);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_zero_spike;
        test_round_robin;
        test_backpressure;
        test_timeout;
        test_reset_mid_issue;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_event_scheduler.md
CONV_EVENT_SCHEDULER -- requirements
Module: conv_event_scheduler

Interface
REQ-001 SHALL take parameter N_SRC, default 4: number of event requesters, 1..8.
REQ-002 SHALL take parameter FIFO_DEPTH, default 8: event queue depth, power of two >= 2.
REQ-003 SHALL take parameter ACK_TIMEOUT, default 255: maximum cycles to wait for conv_ack.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port src_valid, input, N_SRC bits: per-requester event valid.
REQ-007 SHALL have port src_event, input, N_SRC x output_vector_t: per-requester event (timestep, x, y, spikes).
REQ-008 SHALL have port src_ready, output, N_SRC bits: per-requester accept, one-hot or zero.
REQ-009 SHALL have port conv_event, output, output_vector_t: event presented to Convolution2d event_in.
REQ-010 SHALL have port conv_valid, output, 1 bit: drives Convolution2d event_valid.
REQ-011 SHALL have port conv_ack, input, 1 bit: from Convolution2d event_ack.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: queued events.
REQ-013 SHALL have port busy, output, 1 bit: high when FIFO non-empty or FSM not IDLE.
REQ-014 SHALL have port err_timeout, output, 1 bit: sticky ack-timeout flag.
REQ-015 SHALL have port clear_err, input, 1 bit: synchronous clear of err_timeout.

Function
REQ-016 SHALL grant round-robin: priority starts at the index after the last accepted requester; after reset index 0 has highest priority.
REQ-017 SHALL drive src_ready combinationally: only the granted valid requester is high, and only when the registered FIFO state is not full.
REQ-018 SHALL accept at most one event per cycle; transfer occurs when src_valid[i] and src_ready[i] are both high.
REQ-019 SHALL silently drop accepted events with spikes == 0; they are not written to the FIFO.
REQ-020 SHALL run the issue FSM with states IDLE, ISSUE and GAP.
REQ-021 IDLE: if FIFO non-empty, pop the head into the conv_event register and enter ISSUE; conv_valid goes high that next cycle.
REQ-022 ISSUE: hold conv_valid=1 and conv_event stable until conv_ack is sampled high; then enter GAP.
REQ-023 GAP: conv_valid=0 for exactly one cycle, then return to IDLE, so every event presents a fresh rising edge of valid.
REQ-024 SHALL fix latency from accept at edge t (FIFO empty, FSM IDLE) to first conv_valid high at edge t+2.
REQ-025 ISSUE: count cycles; when the count reaches ACK_TIMEOUT without ack, set err_timeout, discard the event, and enter GAP.
REQ-026 SHALL allow simultaneous FIFO push and pop in one cycle, including when full; fifo_count is unchanged and full-state ready is not bypassed.
REQ-027 SHALL give clear_err priority over a simultaneous timeout set; the flag is clear after that cycle.
REQ-028 SHALL ignore conv_ack in IDLE and GAP.

Reset
REQ-029 On rst: FIFO empty, fifo_count=0, FSM IDLE, conv_valid=0, conv_event=0, err_timeout=0, round-robin pointer=0, timeout counter=0.
REQ-030 Reset mid-ISSUE: conv_valid drops asynchronously, and the in-flight and queued events are lost.

Structure
REQ-031 output_vector_t and new constants SCHED_DEFAULT_DEPTH and SCHED_DEFAULT_TIMEOUT SHALL live in snn_interfaces_pkg.
REQ-032 SHALL instantiate one sub-module, event_fifo: a synchronous FIFO of output_vector_t with full, empty and count outputs; arbiter and FSM stay in the top module.

Verification
REQ-033 Single event (t=0, x=5, y=3, spikes=2'b11) from src 0, ack 3 cycles after valid -> conv_valid high at t+2, event unchanged, one GAP cycle, busy low afterwards.
REQ-034 All 4 sources valid continuously, immediate ack -> issue order 0,1,2,3,0,... with no source starved.
REQ-035 Acks withheld, 12 events offered -> fifo_count saturates at 8, src_ready all 0; release acks -> all 9 events (8 queued + 1 in flight) issued in order.
REQ-036 Event with spikes=0 -> src_ready handshake completes, fifo_count stays 0, conv_valid never asserts.
REQ-037 No ack for 255 cycles -> err_timeout=1, conv_valid=0 next cycle, next event issued; clear_err -> err_timeout=0.
REQ-038 rst asserted during ISSUE with 3 queued -> conv_valid 0 immediately, fifo_count 0, RR pointer restarts at 0.
